// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency word-array responder for imem/dmem requests
// Optional MEM_STALL_INJECT_EN adds 0..3 LFSR-chosen wait cycles per accepted request.
module memory_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_fcn,
  input  logic [2:0]  req_typ,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] MT_B = 3'd1, MT_H = 3'd2, MT_BU = 3'd5, MT_HU = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [4:0]  load_cnt;
  logic [4:0]  stall;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [3:0]    be;
  logic          misal;
  logic [31:0]   load;
  logic          unused_addr;

  assign accept      = req_valid && req_ready;
  assign idx         = req_addr[AW+1:2];
  assign unused_addr = &{1'b0, req_addr[31:AW+2]};
  assign word        = mem[idx];
  assign lane_byte   = word[{req_addr[1:0], 3'b000} +: 8];
  assign lane_half   = req_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    be    = 4'b1111;
    misal = |req_addr[1:0];
    load  = word;
    case (req_typ)
      MT_B: begin
        be    = 4'b0001 << req_addr[1:0];
        misal = 1'b0;
        load  = {{24{lane_byte[7]}}, lane_byte};
      end
      MT_BU: begin
        be    = 4'b0001 << req_addr[1:0];
        misal = 1'b0;
        load  = {24'd0, lane_byte};
      end
      MT_H: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        misal = req_addr[0];
        load  = {{16{lane_half[15]}}, lane_half};
      end
      MT_HU: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        misal = req_addr[0];
        load  = {16'd0, lane_half};
      end
      default: ;
    endcase
  end

`ifdef MEM_STALL_INJECT_EN
  logic [7:0] lfsr;

  // Fibonacci taps 8,6,5,4; current value picks this request's stall, then advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 8'hA5;
    else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = {3'd0, lfsr[1:0]};
`else
  assign stall = 5'd0;
`endif

  assign load_cnt = 5'(LATENCY - 1) + stall;

  always_ff @(posedge clk) begin
    if (reset && accept && req_fcn && !misal) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_err   <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_WAIT: begin
          if (cnt == 5'd1) begin
            state     <= S_RESP;
            cnt       <= 5'd0;
            res_valid <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
          if (accept) begin
            res_data <= (req_fcn || misal) ? 32'd0 : load;
            res_err  <= misal;
            cnt      <= load_cnt;
            if (load_cnt == 5'd0) begin
              state     <= S_RESP;
              res_valid <= 1'b1;
              req_ready <= 1'b1;
            end else begin
              state     <= S_WAIT;
              req_ready <= 1'b0;
            end
          end else begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed self-checking bench for memory_responder
module tb_memory_responder;

  localparam logic [2:0] MT_B = 3'd1, MT_H = 3'd2, MT_W = 3'd3, MT_BU = 3'd5, MT_HU = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3 = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic v1 = 0, f1 = 0; logic [2:0] t1 = 0; logic [31:0] a1 = 0, d1 = 0;
  logic rdy1, rv1, re1; logic [31:0] rd1;
  logic v4 = 0, f4 = 0; logic [2:0] t4 = 0; logic [31:0] a4 = 0, d4 = 0;
  logic rdy4, rv4, re4; logic [31:0] rd4;
  logic v3 = 0, f3 = 0; logic [2:0] t3 = 0; logic [31:0] a3 = 0, d3 = 0;
  logic rdy3, rv3, re3; logic [31:0] rd3;

  memory_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u1 (
    .clk(clk), .reset(rst_n), .req_valid(v1), .req_ready(rdy1), .req_addr(a1), .req_data(d1),
    .req_fcn(f1), .req_typ(t1), .res_valid(rv1), .res_data(rd1), .res_err(re1));
  memory_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u4 (
    .clk(clk), .reset(rst_n), .req_valid(v4), .req_ready(rdy4), .req_addr(a4), .req_data(d4),
    .req_fcn(f4), .req_typ(t4), .res_valid(rv4), .res_data(rd4), .res_err(re4));
  memory_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u3 (
    .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3), .req_addr(a3), .req_data(d3),
    .req_fcn(f3), .req_typ(t3), .res_valid(rv3), .res_data(rd3), .res_err(re3));

  // Called at a negedge; presents a request and samples the following cycle (LATENCY=1 instance).
  task automatic txn1(input logic f, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                      output logic rv, output logic [31:0] rd, output logic re);
    v1 = 1'b1; f1 = f; t1 = t; a1 = a; d1 = d;
    @(negedge clk);
    rv = rv1; rd = rd1; re = re1;
  endtask

  task automatic idle1();
    v1 = 1'b0;
    @(negedge clk);
  endtask

  // Request then bounded wait for the response; lat counts cycles after the accept edge.
  task automatic txw1(input logic f, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd);
    v1 = 1'b1; f1 = f; t1 = t; a1 = a; d1 = d;
    @(negedge clk);
    lat = 1; v1 = 1'b0;
    while (!rv1 && lat < 20) begin @(negedge clk); lat++; end
    rd = rd1;
  endtask

  task automatic txw3(input logic f, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd);
    v3 = 1'b1; f3 = f; t3 = t; a3 = a; d3 = d;
    @(negedge clk);
    lat = 1; v3 = 1'b0;
    while (!rv3 && lat < 20) begin @(negedge clk); lat++; end
    rd = rd3;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", rdy1); end
    total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", rv1); end
    total++; if (rd1 !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", rd1); end
    total++; if (re1 !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", re1); end
    total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL rst3_ready: got %b want 1", rdy3); end
    rst_n = 1'b1; rst3 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic rv, re; logic [31:0] rd;
    txn1(1'b1, MT_W, 32'h10, 32'hDEADBEEF, rv, rd, re);
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL b2b_wr_valid: got %b want 1", rv); end
    total++; if (rd !== 32'd0 || re !== 1'b0) begin bad++; $display("FAIL b2b_wr_resp: got %h/%b want 0/0", rd, re); end
    txn1(1'b0, MT_W, 32'h10, 32'h0, rv, rd, re);
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL b2b_rd_valid: got %b want 1", rv); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_rd_data: got %h want deadbeef", rd); end
    total++; if (re !== 1'b0) begin bad++; $display("FAIL b2b_rd_err: got %b want 0", re); end
    idle1();
    total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid: got %b want 0", rv1); end
  endtask

  task automatic test_byte_lanes();
    logic rv, re; logic [31:0] rd;
    txn1(1'b1, MT_B, 32'h11, 32'h0000_8000, rv, rd, re);
    total++; if (re !== 1'b0) begin bad++; $display("FAIL wrb_err: got %b want 0", re); end
    txn1(1'b0, MT_B, 32'h11, 32'h0, rv, rd, re);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL rd_b: got %h want ffffff80", rd); end
    txn1(1'b0, MT_BU, 32'h11, 32'h0, rv, rd, re);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL rd_bu: got %h want 00000080", rd); end
    txn1(1'b0, MT_W, 32'h10, 32'h0, rv, rd, re);
    total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL rd_w_merge: got %h want dead80ef", rd); end
    txn1(1'b0, MT_H, 32'h12, 32'h0, rv, rd, re);
    total++; if (rd !== 32'hFFFFDEAD) begin bad++; $display("FAIL rd_h_hi: got %h want ffffdead", rd); end
    txn1(1'b0, MT_HU, 32'h10, 32'h0, rv, rd, re);
    total++; if (rd !== 32'h000080EF) begin bad++; $display("FAIL rd_hu_lo: got %h want 000080ef", rd); end
    idle1();
  endtask

  task automatic test_misaligned();
    logic rv, re; logic [31:0] rd;
    txn1(1'b0, MT_H, 32'h13, 32'h0, rv, rd, re);
    total++; if (rv !== 1'b1 || re !== 1'b1) begin bad++; $display("FAIL mis_h: got v=%b e=%b want 1/1", rv, re); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL mis_h_data: got %h want 0", rd); end
    txn1(1'b1, MT_W, 32'h12, 32'h12345678, rv, rd, re);
    total++; if (re !== 1'b1) begin bad++; $display("FAIL mis_w_err: got %b want 1", re); end
    txn1(1'b1, MT_HU, 32'h11, 32'h00AB_CD00, rv, rd, re);
    total++; if (re !== 1'b1) begin bad++; $display("FAIL mis_hu_err: got %b want 1", re); end
    txn1(1'b0, MT_W, 32'h10, 32'h0, rv, rd, re);
    total++; if (rd !== 32'hDEAD80EF || re !== 1'b0) begin bad++; $display("FAIL mis_unchanged: got %h/%b want dead80ef/0", rd, re); end
    txn1(1'b0, MT_W, 32'h1010, 32'h0, rv, rd, re);
    total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL addr_wrap: got %h want dead80ef", rd); end
    idle1();
  endtask

  task automatic test_latency4();
    v4 = 1'b1; f4 = 1'b1; t4 = MT_W; a4 = 32'h20; d4 = 32'h11223344;
    @(negedge clk);
    f4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++; if (rdy4 !== (c == 4)) begin bad++; $display("FAIL lat4_ready c%0d: got %b want %b", c, rdy4, (c == 4)); end
      total++; if (rv4 !== (c == 4)) begin bad++; $display("FAIL lat4_valid c%0d: got %b want %b", c, rv4, (c == 4)); end
      if (c < 4) @(negedge clk);
    end
    total++; if (rd4 !== 32'd0) begin bad++; $display("FAIL lat4_wr_data: got %h want 0", rd4); end
    @(negedge clk);
    v4 = 1'b0;
    total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL lat4_second_accept: got %b want 0", rdy4); end
    for (int c = 6; c <= 8; c++) begin
      @(negedge clk);
      total++; if (rv4 !== (c == 8)) begin bad++; $display("FAIL lat4_valid2 c%0d: got %b want %b", c, rv4, (c == 8)); end
    end
    total++; if (rd4 !== 32'h11223344) begin bad++; $display("FAIL lat4_rd_data: got %h want 11223344", rd4); end
  endtask

  task automatic test_reset_in_wait();
    int lat; logic [31:0] rd; int seen;
    txw3(1'b1, MT_W, 32'h40, 32'hCAFEF00D, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("FAIL lat3_wr: got %0d want 3", lat); end
    v3 = 1'b1; f3 = 1'b0; t3 = MT_W; a3 = 32'h40;
    @(negedge clk);
    v3 = 1'b0; rst3 = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rv3) seen++;
      total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL rst3_ready c%0d: got %b want 1", c, rdy3); end
    end
    rst3 = 1'b1;
    repeat (5) begin @(negedge clk); if (rv3) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst3_dropped: got %0d responses want 0", seen); end
    txw3(1'b0, MT_W, 32'h40, 32'h0, lat, rd);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL rst3_persist: got %h want cafef00d", rd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL lat3_rd: got %0d want 3", lat); end
  endtask

  task automatic test_stall();
    logic [31:0] model [16];
    logic [31:0] rd; int lat; int idx;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      txw1(1'b1, MT_W, 32'h100 + 32'(4 * i), model[i], lat, rd);
    end
    for (int n = 0; n < 100; n++) begin
      idx = $urandom_range(15);
      txw1(1'b0, MT_W, 32'h100 + 32'(4 * idx), 32'h0, lat, rd);
      total++; if (lat < 1 || lat > 4) begin bad++; $display("FAIL stall_lat n%0d: got %0d want 1..4", n, lat); end
      total++; if (rd !== model[idx]) begin bad++; $display("FAIL stall_data n%0d: got %h want %h", n, rd, model[idx]); end
    end
  endtask

  initial begin
    test_reset();
`ifdef MEM_STALL_INJECT_EN
    test_stall();
`else
    test_back_to_back();
    test_byte_lanes();
    test_misaligned();
    test_latency4();
    test_reset_in_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
